// File: rtl/encoder_4x2_pending_if.sv
// Request/code bus between event sources, the encoder and its consumer.
// The master side drives requests and ack; the slave side is the encoder.
interface encoder_4x2_pending_if;
    logic       en;
    logic [3:0] d;
    logic       ack;
    logic [1:0] y;
    logic       valid;
    logic [3:0] pending;

    modport master (
        output en,
        output d,
        output ack,
        input  y,
        input  valid,
        input  pending
    );

    modport slave (
        input  en,
        input  d,
        input  ack,
        output y,
        output valid,
        output pending
    );
endinterface

// File: rtl/encoder_4x2_pending.sv
// Sequential 4-to-2 event encoder with a pending register and valid/ack.
// ENCODER_RR_EN selects round-robin instead of fixed highest-bit priority.
module encoder_4x2_pending (
    input  logic                      clk,
    input  logic                      rst_n,
    encoder_4x2_pending_if.slave      bus
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] pending_q;
    logic [3:0] pending_nxt;
    logic [3:0] clr;
    logic [1:0] y_q;
    logic [1:0] y_nxt;
    logic       valid_q;
    logic       valid_nxt;
    logic [1:0] sel;
    logic       accept;

    assign accept = valid_q && bus.ack;

`ifdef ENCODER_RR_EN
    logic [1:0] last;
    logic [1:0] start;

    assign start = last + 2'd1;

    // Search from the slot after the last accepted index, wrapping
    always_comb begin
        logic       found;
        logic [1:0] idx;
        sel   = start;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && pending_q[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // Pointer remembers the most recently accepted index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 2'b11;
        end else if (accept) begin
            last <= y_q;
        end
    end
`else
    // Fixed priority: highest pending bit wins
    always_comb begin
        sel = 2'd0;
        if (pending_q[3]) begin
            sel = 2'd3;
        end else if (pending_q[2]) begin
            sel = 2'd2;
        end else if (pending_q[1]) begin
            sel = 2'd1;
        end else begin
            sel = 2'd0;
        end
    end
`endif

    // New requests are OR-ed in after the clear, so set beats clear
    always_comb begin
        clr = 4'b0000;
        if (accept) begin
            clr = 4'(1) << y_q;
        end
        pending_nxt = (pending_q & ~clr)
                    | (bus.en ? bus.d : 4'b0000);
    end

    // Handshake FSM: present one code, hold it until acknowledged
    always_comb begin
        state_nxt = state;
        y_nxt     = y_q;
        valid_nxt = valid_q;
        unique case (state)
            IDLE: begin
                if (pending_q != 4'b0000) begin
                    y_nxt     = sel;
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.ack) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // State, code and pending registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            y_q       <= 2'b00;
            valid_q   <= 1'b0;
            pending_q <= 4'b0000;
        end else begin
            state     <= state_nxt;
            y_q       <= y_nxt;
            valid_q   <= valid_nxt;
            pending_q <= pending_nxt;
        end
    end

    assign bus.y       = y_q;
    assign bus.valid   = valid_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_encoder_4x2_pending.sv
// Directed self-checking bench for encoder_4x2_pending.
// Round-robin scenario runs when ENCODER_RR_EN is defined.
module tb_encoder_4x2_pending;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    encoder_4x2_pending_if bus ();

    encoder_4x2_pending dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.en  = 1'b1;
        bus.d   = 4'b0000;
        bus.ack = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.pending !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_pending: got %b want 0000", bus.pending);
        end
        n_cmp++;
        if (bus.valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b want 0", bus.valid);
        end
        n_cmp++;
        if (bus.y !== 2'b00) begin
            n_err++;
            $display("FAIL reset_y: got %b want 00", bus.y);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        bus.d = 4'b1010;
        step();
        bus.d = 4'b0000;
        step();
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.y !== 2'd3) begin
            n_err++;
            $display("FAIL midhold_setup: got v=%b y=%0d want v=1 y=3",
                     bus.valid, bus.y);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.pending !== 4'b0000 || bus.valid !== 1'b0
            || bus.y !== 2'b00) begin
            n_err++;
            $display("FAIL midhold_reset: got p=%b v=%b y=%0d want 0/0/0",
                     bus.pending, bus.valid, bus.y);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        idle_inputs();
        bus.d = 4'b0100;
        step();
        bus.d = 4'b0000;
        n_cmp++;
        if (bus.pending !== 4'b0100 || bus.valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_capture: got p=%b v=%b want 0100 0",
                     bus.pending, bus.valid);
        end
        step();
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.y !== 2'd2) begin
            n_err++;
            $display("FAIL single_present: got v=%b y=%0d want 1 2",
                     bus.valid, bus.y);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (bus.valid !== 1'b1 || bus.y !== 2'd2) begin
                n_err++;
                $display("FAIL single_hold%0d: got v=%b y=%0d want 1 2",
                         i, bus.valid, bus.y);
            end
        end
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        n_cmp++;
        if (bus.valid !== 1'b0 || bus.pending !== 4'b0000) begin
            n_err++;
            $display("FAIL single_ack: got v=%b p=%b want 0 0000",
                     bus.valid, bus.pending);
        end
        step();
        n_cmp++;
        if (bus.valid !== 1'b0 || bus.y !== 2'd2) begin
            n_err++;
            $display("FAIL single_after: got v=%b y=%0d want 0 2",
                     bus.valid, bus.y);
        end
    endtask

`ifndef ENCODER_RR_EN
    task automatic test_priority();
        logic [1:0] exp_y [3];
        logic [3:0] exp_p [3];
        exp_y = '{2'd3, 2'd1, 2'd0};
        exp_p = '{4'b0011, 4'b0001, 4'b0000};
        idle_inputs();
        bus.d = 4'b1011;
        step();
        bus.d = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (bus.valid !== 1'b1 || bus.y !== exp_y[i]) begin
                n_err++;
                $display("FAIL prio_code%0d: got v=%b y=%0d want 1 %0d",
                         i, bus.valid, bus.y, exp_y[i]);
            end
            bus.ack = 1'b1;
            step();
            bus.ack = 1'b0;
            n_cmp++;
            if (bus.pending !== exp_p[i]) begin
                n_err++;
                $display("FAIL prio_pend%0d: got %b want %b",
                         i, bus.pending, exp_p[i]);
            end
        end
        step();
        step();
        n_cmp++;
        if (bus.valid !== 1'b0) begin
            n_err++;
            $display("FAIL prio_drain: got v=%b want 0", bus.valid);
        end
    endtask
`else
    task automatic test_round_robin();
        logic [1:0] exp_y [5];
        exp_y = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        idle_inputs();
        bus.d = 4'b1111;
        step();
        bus.d = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) bus.d = 4'b0001;
            step();
            bus.d = 4'b0000;
            n_cmp++;
            if (bus.valid !== 1'b1 || bus.y !== exp_y[i]) begin
                n_err++;
                $display("FAIL rr_code%0d: got v=%b y=%0d want 1 %0d",
                         i, bus.valid, bus.y, exp_y[i]);
            end
            bus.ack = 1'b1;
            step();
            bus.ack = 1'b0;
        end
        step();
        n_cmp++;
        if (bus.valid !== 1'b0 || bus.pending !== 4'b0000) begin
            n_err++;
            $display("FAIL rr_drain: got v=%b p=%b want 0 0000",
                     bus.valid, bus.pending);
        end
    endtask
`endif

    task automatic test_collision();
        idle_inputs();
        bus.d = 4'b0010;
        step();
        bus.d = 4'b0000;
        step();
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.y !== 2'd1) begin
            n_err++;
            $display("FAIL coll_setup: got v=%b y=%0d want 1 1",
                     bus.valid, bus.y);
        end
        bus.ack = 1'b1;
        bus.d   = 4'b0010;
        step();
        bus.ack = 1'b0;
        bus.d   = 4'b0000;
        n_cmp++;
        if (bus.pending !== 4'b0010 || bus.valid !== 1'b0) begin
            n_err++;
            $display("FAIL coll_set_wins: got p=%b v=%b want 0010 0",
                     bus.pending, bus.valid);
        end
        step();
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.y !== 2'd1) begin
            n_err++;
            $display("FAIL coll_represent: got v=%b y=%0d want 1 1",
                     bus.valid, bus.y);
        end
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        step();
    endtask

    task automatic test_enable();
        idle_inputs();
        bus.en = 1'b0;
        bus.d  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            bus.ack = i[0];
            step();
            n_cmp++;
            if (bus.pending !== 4'b0000 || bus.valid !== 1'b0) begin
                n_err++;
                $display("FAIL en_gate%0d: got p=%b v=%b want 0000 0",
                         i, bus.pending, bus.valid);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        bus.d = 4'b1000;
        step();
        bus.d = 4'b0000;
        step();
        bus.ack = 1'b1;
        bus.d   = 4'b0001;
        step();
        bus.ack = 1'b0;
        bus.d   = 4'b0000;
        bus.en  = 1'b0;
        step();
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.y !== 2'd0) begin
            n_err++;
            $display("FAIL b2b_next: got v=%b y=%0d want 1 0",
                     bus.valid, bus.y);
        end
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        n_cmp++;
        if (bus.pending !== 4'b0000 || bus.valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drain: got p=%b v=%b want 0000 0",
                     bus.pending, bus.valid);
        end
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
`ifndef ENCODER_RR_EN
        test_priority();
`else
        test_round_robin();
`endif
        test_collision();
        test_enable();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
